// File: rtl/turtle_cpu_pkg.sv
// turtle_cpu_pkg: shared types for the turtle CPU board glue
package turtle_cpu_pkg;
  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    RUN        = 3'd1,
    STEP_WAIT  = 3'd2,
    STEP_PULSE = 3'd3,
    HALTED     = 3'd4
  } run_state_t;
endpackage

// File: rtl/turtle_debouncer.sv
// turtle_debouncer: 2-flop synchronizer plus consecutive-sample debouncer for one raw board input
module turtle_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic db_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1_q, s2_q;
  logic [CW-1:0] cnt_q;
  logic full;
  assign full = cnt_q == CW'(DEBOUNCE_CYCLES);
  always_ff @(posedge clk)
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      cnt_q <= '0;
      db_o <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      cnt_q <= (s2_q == db_o || full) ? '0 : cnt_q + 1'b1;
      if (s2_q != db_o && full) db_o <= ~db_o;
    end
endmodule

// File: rtl/turtle_run_controller.sv
// turtle_run_controller: free-run / single-step / halt sequencing of the turtle core clock enable
module turtle_run_controller
  import turtle_cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int RUN_DIVIDER       = 4,
  parameter int RESET_HOLD_CYCLES = 8,
  parameter int PC_WIDTH          = 10,
  parameter int COUNT_WIDTH       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   manual_clk_sw,
  input  logic                   pulse_clk_btn,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic                   halt_instr,
  input  logic                   bp_enable,
  input  logic [PC_WIDTH-1:0]    bp_addr,
  output logic                   core_reset,
  output logic                   cpu_clk_en,
  output logic                   halted,
  output logic [2:0]             run_state,
  output logic [COUNT_WIDTH-1:0] cycle_count
);
  localparam int DW = $clog2(RUN_DIVIDER);
  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  run_state_t state_q;
  logic [DW-1:0] div_q;
  logic [HW-1:0] hold_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic rst_q, en_q, halted_q, btn_prev_q, press_q;
  logic sw_db, btn_db, tick, stop;
  turtle_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
    .clk(clk), .reset(reset), .raw_i(manual_clk_sw), .db_o(sw_db)
  );
  turtle_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk(clk), .reset(reset), .raw_i(pulse_clk_btn), .db_o(btn_db)
  );
  assign tick = div_q == DW'(RUN_DIVIDER - 1);
  assign stop = halt_instr | (bp_enable & (pc == bp_addr));
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= RESET_HOLD;
      div_q <= '0;
      hold_q <= '0;
      cnt_q <= '0;
      rst_q <= 1'b1;
      en_q <= 1'b0;
      halted_q <= 1'b0;
      btn_prev_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      btn_prev_q <= btn_db;
      press_q <= btn_db & ~btn_prev_q;
      if (en_q && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      en_q <= 1'b0;
      case (state_q)
        RESET_HOLD:
          if (hold_q == HW'(RESET_HOLD_CYCLES - 1)) begin
            rst_q <= 1'b0;
            div_q <= '0;
            state_q <= sw_db ? STEP_WAIT : RUN;
          end else hold_q <= hold_q + 1'b1;
        RUN: begin
          div_q <= tick ? '0 : div_q + 1'b1;
          if (tick) en_q <= ~stop;
          if (tick && stop) begin
            state_q <= HALTED;
            halted_q <= 1'b1;
          end else if (sw_db) state_q <= STEP_WAIT;
        end
        STEP_WAIT:
          if (!sw_db) begin
            state_q <= RUN;
            div_q <= '0;
          end else if (press_q) begin
            state_q <= halt_instr ? HALTED : STEP_PULSE;
            halted_q <= halt_instr;
            en_q <= ~halt_instr;
          end
        STEP_PULSE: state_q <= STEP_WAIT;
        HALTED:
          if (sw_db && press_q && !halt_instr) begin
            state_q <= STEP_PULSE;
            halted_q <= 1'b0;
            en_q <= 1'b1;
          end
        default: begin
          state_q <= RESET_HOLD;
          hold_q <= '0;
          rst_q <= 1'b1;
          halted_q <= 1'b0;
        end
      endcase
    end
  assign core_reset = rst_q;
  assign cpu_clk_en = en_q;
  assign halted = halted_q;
  assign run_state = state_q;
  assign cycle_count = cnt_q;
endmodule

// File: tb/tb_turtle_run_controller.sv
// tb_turtle_run_controller: scoreboard bench checking clock-enable pulse timing and FSM status
module tb_turtle_run_controller;
  logic clk = 1'b0;
  logic reset, sw, btn, halt, bp_en;
  logic [9:0] pc, bp_addr;
  logic core_reset, en, halted;
  logic [2:0] run_state;
  logic [31:0] count;
  logic s_rst, s_en, s_halted;
  logic [2:0] s_state, s_count;
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int q[$];
  int t, r;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) pc <= reset ? 10'd0 : en ? pc + 10'd1 : pc;
  turtle_run_controller #(
    .DEBOUNCE_CYCLES(4), .RUN_DIVIDER(4), .RESET_HOLD_CYCLES(8), .PC_WIDTH(10), .COUNT_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .manual_clk_sw(sw), .pulse_clk_btn(btn), .pc(pc),
    .halt_instr(halt), .bp_enable(bp_en), .bp_addr(bp_addr), .core_reset(core_reset),
    .cpu_clk_en(en), .halted(halted), .run_state(run_state), .cycle_count(count)
  );
  turtle_run_controller #(
    .DEBOUNCE_CYCLES(4), .RUN_DIVIDER(2), .RESET_HOLD_CYCLES(2), .PC_WIDTH(10), .COUNT_WIDTH(3)
  ) dut_sat (
    .clk(clk), .reset(reset), .manual_clk_sw(1'b0), .pulse_clk_btn(1'b0), .pc(10'd0),
    .halt_instr(1'b0), .bp_enable(1'b0), .bp_addr(10'd0), .core_reset(s_rst),
    .cpu_clk_en(s_en), .halted(s_halted), .run_state(s_state), .cycle_count(s_count)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic press(input int hold);
    btn = 1'b1;
    repeat (hold) @(negedge clk);
    btn = 1'b0;
  endtask
  always @(negedge clk)
    if (en === 1'b1) begin
      check("pulse_cyc", 64'(cyc), 64'(q.size() != 0 ? q.pop_front() : -1));
      check("en_vs_core_reset", 64'(core_reset), 64'd0);
    end
  initial begin
    reset = 1'b1; sw = 1'b0; btn = 1'b0; halt = 1'b0; bp_en = 1'b1; bp_addr = 10'h00A;
    wait_until(3);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_en", 64'(en), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_state", 64'(run_state), 64'd0);
    r = cyc;
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) q.push_back(r + 8 + 4 * k);
    wait_until(r + 7);
    check("hold_core_reset", 64'(core_reset), 64'd1);
    wait_until(r + 8);
    check("hold_release", 64'(core_reset), 64'd0);
    check("enter_run", 64'(run_state), 64'd1);
    wait_until(r + 30);
    check("count_5", 64'(count), 64'd5);
    wait_until(r + 53);
    check("bp_halted", 64'(halted), 64'd1);
    check("bp_state", 64'(run_state), 64'd4);
    check("bp_count", 64'(count), 64'd10);
    wait_until(r + 60);
    check("bp_frozen", 64'(count), 64'd10);
    sw = 1'b1;
    wait_until(cyc + 12);
    check("sw_no_exit", 64'(run_state), 64'd4);
    press(3);
    wait_until(cyc + 12);
    check("glitch_halted", 64'(halted), 64'd1);
    t = cyc;
    q.push_back(t + 9);
    press(10);
    wait_until(t + 12);
    check("step_bp_state", 64'(run_state), 64'd2);
    check("step_bp_halted", 64'(halted), 64'd0);
    wait_until(t + 25);
    t = cyc;
    q.push_back(t + 9);
    press(10);
    wait_until(t + 25);
    check("step_count", 64'(count), 64'd12);
    check("step_state", 64'(run_state), 64'd2);
    bp_addr = 10'h00E;
    t = cyc;
    sw = 1'b0;
    q.push_back(t + 12);
    q.push_back(t + 16);
    wait_until(t + 8);
    check("resume_run", 64'(run_state), 64'd1);
    wait_until(t + 21);
    check("rearm_halted", 64'(halted), 64'd1);
    check("rearm_count", 64'(count), 64'd14);
    reset = 1'b1;
    t = cyc;
    wait_until(t + 1);
    check("midreset_state", 64'(run_state), 64'd0);
    check("midreset_core_reset", 64'(core_reset), 64'd1);
    check("midreset_count", 64'(count), 64'd0);
    bp_en = 1'b0;
    wait_until(t + 3);
    reset = 1'b0;
    r = cyc;
    q.push_back(r + 12);
    q.push_back(r + 16);
    wait_until(r + 17);
    halt = 1'b1;
    wait_until(r + 21);
    check("hlt_halted", 64'(halted), 64'd1);
    check("hlt_count", 64'(count), 64'd2);
    sw = 1'b1;
    wait_until(cyc + 12);
    press(10);
    wait_until(cyc + 15);
    check("hlt_press_state", 64'(run_state), 64'd4);
    check("hlt_press_count", 64'(count), 64'd2);
    reset = 1'b1;
    wait_until(cyc + 1);
    check("hlt_reset_state", 64'(run_state), 64'd0);
    halt = 1'b0;
    wait_until(cyc + 2);
    reset = 1'b0;
    r = cyc;
    wait_until(r + 8);
    check("reset_to_step", 64'(run_state), 64'd2);
    wait_until(r + 9);
    check("sat_count_3", 64'(s_count), 64'd3);
    t = cyc;
    q.push_back(t + 9);
    btn = 1'b1;
    wait_until(t + 9);
    reset = 1'b1;
    wait_until(t + 10);
    btn = 1'b0;
    check("pulse_reset_en", 64'(en), 64'd0);
    check("pulse_reset_count", 64'(count), 64'd0);
    check("pulse_reset_core", 64'(core_reset), 64'd1);
    check("pulse_reset_state", 64'(run_state), 64'd0);
    wait_until(t + 12);
    reset = 1'b0;
    wait_until(t + 52);
    check("sat_count_max", 64'(s_count), 64'd7);
    check("sat_state", 64'(s_state), 64'd1);
    check("sb_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
